// File: rtl/cpu_branch_resolver.sv
// cpu_branch_resolver: branch condition evaluation, redirect/mispredict detection, bimodal BHT and stats
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   flush                drops this cycle's resolve and the next-edge result
//   lookup_pc            fetch PC to predict
//   lookup_taken         MSB of the BHT counter for lookup_pc
//   res_valid/res_ready  resolve handshake
//   res_mod              condition code (funct3)
//   res_a, res_b         operands
//   res_pc, res_offset   branch PC and sign-extended offset
//   res_predicted        direction fetch predicted
//   out_*                registered result, out_valid for one cycle per accept
//   stat_branches        saturating count of accepted resolves
//   stat_mispredicts     saturating count of mispredicted resolves
module cpu_branch_resolver #(
    parameter int XLEN        = 32,
    parameter int PC_WIDTH    = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int STAT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [PC_WIDTH-1:0]   lookup_pc,
    output logic                  lookup_taken,
    input  logic                  res_valid,
    output logic                  res_ready,
    input  logic [2:0]            res_mod,
    input  logic [XLEN-1:0]       res_a,
    input  logic [XLEN-1:0]       res_b,
    input  logic [PC_WIDTH-1:0]   res_pc,
    input  logic [PC_WIDTH-1:0]   res_offset,
    input  logic                  res_predicted,
    output logic                  out_valid,
    output logic                  out_taken,
    output logic                  out_mispredict,
    output logic [PC_WIDTH-1:0]   out_redirect_pc,
    output logic [STAT_WIDTH-1:0] stat_branches,
    output logic [STAT_WIDTH-1:0] stat_mispredicts
);
    localparam int IDX_W = $clog2(BHT_ENTRIES);

    typedef enum logic {INIT, RUN} state_t;

    state_t           state, state_nx;
    logic [IDX_W-1:0] ptr;
    logic [1:0]       bht [BHT_ENTRIES];
    logic [IDX_W-1:0] res_idx, lookup_idx;
    logic [1:0]       cur, upd;
    logic             accept, taken;

    assign res_idx    = res_pc[IDX_W+1:2];
    assign lookup_idx = lookup_pc[IDX_W+1:2];
    assign accept     = res_valid && res_ready && !flush;

    always_comb begin
        case (res_mod)
            3'b000:  taken = res_a == res_b;
            3'b001:  taken = res_a != res_b;
            3'b100:  taken = $signed(res_a) <  $signed(res_b);
            3'b101:  taken = $signed(res_a) >= $signed(res_b);
            3'b110:  taken = res_a <  res_b;
            3'b111:  taken = res_a >= res_b;
            default: taken = 1'b0;
        endcase
    end

    // 2-bit saturating counter step
    assign cur = bht[res_idx];
    assign upd = taken ? ((cur == 2'b11) ? cur : cur + 2'd1)
                       : ((cur == 2'b00) ? cur : cur - 2'd1);

    // State register; the sweep pointer wraps to 0 as INIT ends
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
            ptr   <= '0;
        end else begin
            state <= state_nx;
            if (state == INIT) ptr <= ptr + 1'b1;
        end
    end

    always_comb state_nx = (state == INIT && ptr == IDX_W'(BHT_ENTRIES - 1)) ? RUN : state;

    // The BHT contents are undefined until the sweep finishes, so the
    // prediction is masked while in INIT
    always_comb begin
        res_ready    = state == RUN;
        lookup_taken = res_ready && bht[lookup_idx][1];
    end

    // Counter array has no reset: INIT sweep rewrites every entry
    always_ff @(posedge clk) begin
        if (state == INIT) bht[ptr] <= 2'b01;
        else if (accept)   bht[res_idx] <= upd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid        <= 1'b0;
            out_taken        <= 1'b0;
            out_mispredict   <= 1'b0;
            out_redirect_pc  <= '0;
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            out_valid <= accept;
            if (accept) begin
                out_taken       <= taken;
                out_mispredict  <= taken != res_predicted;
                out_redirect_pc <= res_pc + (taken ? res_offset : PC_WIDTH'(4));
                if (!(&stat_branches)) stat_branches <= stat_branches + STAT_WIDTH'(1);
                if (taken != res_predicted && !(&stat_mispredicts))
                    stat_mispredicts <= stat_mispredicts + STAT_WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_cpu_branch_resolver.sv
// tb_cpu_branch_resolver: directed vector bench for cpu_branch_resolver
module tb_cpu_branch_resolver;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] lookup_pc = 32'h40;
    logic        res_valid = 1'b0;
    logic [2:0]  res_mod = 3'b0;
    logic [31:0] res_a = '0, res_b = '0, res_pc = '0, res_offset = '0;
    logic        res_predicted = 1'b0;

    logic        lookup_taken, res_ready, out_valid, out_taken, out_mispredict;
    logic [31:0] out_redirect_pc, stat_branches, stat_mispredicts;

    logic        lookup_taken2, res_ready2, out_valid2, out_taken2, out_mispredict2;
    logic [31:0] out_redirect_pc2;
    logic [3:0]  stat_branches2, stat_mispredicts2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cpu_branch_resolver dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .lookup_pc(lookup_pc), .lookup_taken(lookup_taken),
        .res_valid(res_valid), .res_ready(res_ready), .res_mod(res_mod),
        .res_a(res_a), .res_b(res_b), .res_pc(res_pc), .res_offset(res_offset),
        .res_predicted(res_predicted),
        .out_valid(out_valid), .out_taken(out_taken), .out_mispredict(out_mispredict),
        .out_redirect_pc(out_redirect_pc),
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    cpu_branch_resolver #(.BHT_ENTRIES(4), .STAT_WIDTH(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .lookup_pc(lookup_pc), .lookup_taken(lookup_taken2),
        .res_valid(res_valid), .res_ready(res_ready2), .res_mod(res_mod),
        .res_a(res_a), .res_b(res_b), .res_pc(res_pc), .res_offset(res_offset),
        .res_predicted(res_predicted),
        .out_valid(out_valid2), .out_taken(out_taken2), .out_mispredict(out_mispredict2),
        .out_redirect_pc(out_redirect_pc2),
        .stat_branches(stat_branches2), .stat_mispredicts(stat_mispredicts2)
    );

    typedef struct {
        logic [2:0]  mod;
        logic [31:0] a, b, pc, off;
        logic        pred, taken, mis;
        logic [31:0] redir;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic count_init(output int n);
        n = 0;
        do begin
            step();
            n++;
            if (n == 10) chk("init_lookup", 32'(lookup_taken), 0);
        end while (!res_ready && n < 200);
    endtask

    task automatic resolve(input logic [2:0] m, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] pc, input logic [31:0] off, input logic pred);
        res_mod = m; res_a = a; res_b = b; res_pc = pc; res_offset = off; res_predicted = pred;
    endtask

    initial begin
        int n;
        vecs[0]  = '{3'b100, 32'hFFFFFFFF, 32'h1, 32'h200, 32'h20, 1'b1, 1'b1, 1'b0, 32'h220};
        vecs[1]  = '{3'b110, 32'hFFFFFFFF, 32'h1, 32'h200, 32'h20, 1'b1, 1'b0, 1'b1, 32'h204};
        vecs[2]  = '{3'b111, 32'hFFFFFFFF, 32'h1, 32'h200, 32'h20, 1'b0, 1'b1, 1'b1, 32'h220};
        vecs[3]  = '{3'b010, 32'h0,        32'h0, 32'h200, 32'h20, 1'b0, 1'b0, 1'b0, 32'h204};
        vecs[4]  = '{3'b000, 32'h5,        32'h5, 32'h100, 32'hFFFFFFF0, 1'b0, 1'b1, 1'b1, 32'h0F0};
        vecs[5]  = '{3'b001, 32'h5,        32'h5, 32'h100, 32'hFFFFFFF0, 1'b0, 1'b0, 1'b0, 32'h104};
        vecs[6]  = '{3'b101, 32'hFFFFFFFF, 32'h1, 32'h100, 32'h8, 1'b1, 1'b0, 1'b1, 32'h104};
        vecs[7]  = '{3'b011, 32'h1,        32'h2, 32'h100, 32'h8, 1'b0, 1'b0, 1'b0, 32'h104};
        vecs[8]  = '{3'b100, 32'h1, 32'hFFFFFFFF, 32'h100, 32'h8, 1'b0, 1'b0, 1'b0, 32'h104};
        vecs[9]  = '{3'b000, 32'h7,        32'h7, 32'hFFFFFFFC, 32'h8, 1'b1, 1'b1, 1'b0, 32'h4};
        vecs[10] = '{3'b110, 32'h3,        32'h2, 32'hFFFFFFFC, 32'h8, 1'b1, 1'b0, 1'b1, 32'h0};

        // Reset state
        step();
        step();
        chk("rst_ready", 32'(res_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_stat_br", stat_branches, 0);
        chk("rst_redirect", out_redirect_pc, 0);
        rst_n = 1'b1;
        count_init(n);
        chk("init_cycles", n, 64);
        chk("run_lookup_40", 32'(lookup_taken), 0);
        lookup_pc = 32'h1234;
        #1 chk("run_lookup_1234", 32'(lookup_taken), 0);
        lookup_pc = 32'h40;

        // Back-to-back table vectors
        res_valid = 1'b1;
        for (int i = 0; i < 11; i++) begin
            resolve(vecs[i].mod, vecs[i].a, vecs[i].b, vecs[i].pc, vecs[i].off, vecs[i].pred);
            step();
            chk($sformatf("v%0d_valid", i), 32'(out_valid), 1);
            chk($sformatf("v%0d_taken", i), 32'(out_taken), 32'(vecs[i].taken));
            chk($sformatf("v%0d_mis", i), 32'(out_mispredict), 32'(vecs[i].mis));
            chk($sformatf("v%0d_redir", i), out_redirect_pc, vecs[i].redir);
        end
        res_valid = 1'b0;
        step();
        chk("idle_valid", 32'(out_valid), 0);
        chk("idle_hold_mis", 32'(out_mispredict), 1);
        chk("tbl_stat_br", stat_branches, 11);
        chk("tbl_stat_mis", stat_mispredicts, 5);
        chk("tbl_stat_br4", 32'(stat_branches2), 11);
        chk("tbl_stat_mis4", 32'(stat_mispredicts2), 5);

        // BHT counter at pc 0x40: three taken, two not-taken
        resolve(3'b000, 0, 0, 32'h40, 32'h10, 1'b0);
        res_valid = 1'b1;
        #1 chk("bht_no_bypass", 32'(lookup_taken), 0);
        step();
        chk("bht_t1", 32'(lookup_taken), 1);
        step();
        step();
        chk("bht_t3", 32'(lookup_taken), 1);
        res_mod = 3'b001;
        step();
        chk("bht_sat_nt1", 32'(lookup_taken), 1);
        step();
        chk("bht_nt2", 32'(lookup_taken), 0);
        res_valid = 1'b0;
        step();
        chk("bht_stat_br", stat_branches, 16);
        chk("bht_stat_mis", stat_mispredicts, 8);
        chk("sat_stat_br4", 32'(stat_branches2), 32'hF);

        // Flush with a same-cycle resolve
        resolve(3'b000, 0, 0, 32'h40, 32'h10, 1'b0);
        res_valid = 1'b1;
        flush = 1'b1;
        step();
        res_valid = 1'b0;
        flush = 1'b0;
        chk("flush_valid", 32'(out_valid), 0);
        chk("flush_stat_br", stat_branches, 16);
        chk("flush_bht", 32'(lookup_taken), 0);

        // Registered result survives a flush in its own cycle
        resolve(3'b001, 1, 2, 32'h300, 32'h10, 1'b1);
        res_valid = 1'b1;
        step();
        res_valid = 1'b0;
        flush = 1'b1;
        #1 chk("flush_keep_valid", 32'(out_valid), 1);
        chk("flush_keep_redir", out_redirect_pc, 32'h310);
        step();
        flush = 1'b0;
        chk("flush_after_valid", 32'(out_valid), 0);
        chk("final_stat_br", stat_branches, 17);
        chk("final_stat_mis", stat_mispredicts, 8);
        chk("final_stat_br4", 32'(stat_branches2), 32'hF);

        // Asynchronous reset, then another reset in the middle of INIT
        rst_n = 1'b0;
        #1 chk("arst_stat_br", stat_branches, 0);
        chk("arst_stat_mis", stat_mispredicts, 0);
        chk("arst_stat_br4", 32'(stat_branches2), 0);
        chk("arst_ready", 32'(res_ready), 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("mid_init_ready", 32'(res_ready), 0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        count_init(n);
        chk("reinit_cycles", n, 64);
        chk("reinit_lookup", 32'(lookup_taken), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cpu_branch_resolver.md
Name: cpu_branch_resolver

Overview:
Parametrised successor to the combinational branch condition tester. Evaluates the branch condition, computes the redirect target and detects mispredictions with one registered output stage. Owns a bimodal branch history table (BHT) of 2-bit saturating counters, with a combinational lookup port for fetch. Sits between execute and fetch; it also provides saturating branch and mispredict statistics counters.

Parameters:
XLEN, 32, operand width for the comparison.
PC_WIDTH, 32, width of PCs and branch offsets.
BHT_ENTRIES, 64, number of 2-bit counters; must be a power of two, 2 to 1024.
STAT_WIDTH, 32, width of the statistics counters.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
flush  in  1  cancels the output stage and any resolve presented this cycle.
lookup_pc  in  PC_WIDTH  fetch PC to predict.
lookup_taken  out  1  prediction; MSB of the counter at lookup_pc[2 +: IDX_W].
res_valid  in  1  resolve request valid.
res_ready  out  1  resolver can accept a request.
res_mod  in  3  condition code (funct3).
res_a, res_b  in  XLEN  operands.
res_pc  in  PC_WIDTH  PC of the branch.
res_offset  in  PC_WIDTH  sign-extended branch offset.
res_predicted  in  1  direction fetch predicted.
out_valid  out  1  result valid, one cycle per accepted request.
out_taken  out  1  resolved direction.
out_mispredict  out  1  out_taken != registered res_predicted.
out_redirect_pc  out  PC_WIDTH  res_pc+res_offset if taken, else res_pc+4; modulo 2^PC_WIDTH.
stat_branches, stat_mispredicts  out  STAT_WIDTH  saturating counts.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous and active-low.
- IDX_W = log2(BHT_ENTRIES). BHT index = pc[IDX_W+1:2].
- Reset values: all outputs 0, res_ready 0, state INIT, sweep pointer 0.
- FSM state INIT:
  - Writes 2'b01 (weakly not-taken) to one entry per cycle, pointer 0..BHT_ENTRIES-1.
  - res_ready=0, lookup_taken=0.
  - Moves to RUN after the last entry, so INIT lasts exactly BHT_ENTRIES cycles.
- FSM state RUN: res_ready=1; stays in RUN until reset.
- Conditions by res_mod:
  - 000 EQ, 001 NE.
  - 100 LT and 101 GE are signed.
  - 110 LTU and 111 GEU are unsigned.
  - 010 and 011 are never taken.
- Accept: res_valid && res_ready && !flush.
- Latency: one cycle. The accepted request appears on the out_* signals at the next edge, with out_valid=1 for exactly that cycle. Back-to-back accepts give back-to-back results.
- Outputs hold their last values while out_valid=0.
- BHT update: at the accept edge, the counter at res_pc's index is updated, saturating at 00 and 11 (+1 if taken, -1 if not).
- Lookup is a combinational read of the stored array; it returns the pre-update value when it hits the same index in the same cycle (no bypass).
- Stats:
  - On accept, stat_branches increments, and stat_mispredicts increments if mispredicted.
  - Both saturate at all-ones and never wrap.
  - Stats are cleared only by reset.
- flush:
  - The next-edge out_valid is 0.
  - A same-cycle resolve is dropped, with no BHT or stat update.
  - A result already registered still shows for its one cycle.
- Reset mid-operation, including during INIT, returns immediately to the reset values and restarts INIT from entry 0.

Test Plan:
- Release reset with BHT_ENTRIES=64 -> res_ready=0 for 64 cycles, then 1; lookup of any PC gives 0.
- LT with a=0xFFFFFFFF, b=1 -> taken; LTU with the same operands -> not taken; GEU -> taken; mod 010 -> not taken.
- BEQ a=b=5, pc=0x100, offset=0xFFFFFFF0, predicted=0 -> next cycle out_valid=1, taken=1, mispredict=1, redirect=0x0F0; stat_mispredicts=1.
- Three taken resolves at pc=0x40 -> lookup_taken(0x40)=1 after the first; counter saturates at 11, and one not-taken then leaves lookup_taken=1.
- res_valid and flush together -> out_valid stays 0; stat_branches and the BHT entry are unchanged.
- Force stat_branches to all-ones minus 1 (STAT_WIDTH=4), issue 3 accepts -> stat_branches stays 4'hF; assert rst_n low mid-INIT -> all counters 0 and INIT restarts.
